// File: rtl/ds_pkt_pkg.sv
// ds_pkt_pkg -- shared types, constants and helpers for the multi-beat
// packet generator.
//   gen_state_t : generator state machine encoding (IDLE, LOAD, SEND, DONE)
//   LFSR_POLY   : Galois feedback mask used by every payload lane
//   HDR_*_LSB   : bit offsets of the fields in the optional sop header
//   lane_count  : number of 32-bit payload lanes in a beat
//   lfsr_step   : one right-shifting Galois LFSR step
//   build_hdr   : assembles {seq[15:0], len[7:0], 4'h0, addr[3:0]}
package ds_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_SEQ_LSB  = 16;

    function automatic int lane_count(input int data_width);
        return data_width / 32;
    endfunction

    // Right-shifting Galois form: the bit shifted out selects the feedback mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end else begin
            n = n;
        end
        return n;
    endfunction

    function automatic logic [31:0] build_hdr(input logic [15:0] seq,
                                              input logic [7:0]  len,
                                              input logic [3:0]  addr);
        logic [31:0] h;
        h = 32'h0000_0000;
        h[HDR_SEQ_LSB  +: 16] = seq;
        h[HDR_LEN_LSB  +: 8]  = len;
        h[HDR_ADDR_LSB +: 4]  = addr;
        return h;
    endfunction

endpackage

// File: rtl/t_DATA_STREAM.sv
// t_DATA_STREAM -- NAP data-stream interface.
//   valid/ready : AXI-style handshake, a beat moves when both are high
//   data        : DATA_WIDTH payload bits
//   addr        : 4-bit destination NAP address
//   sop/eop     : first / last beat of a packet
// Modport tx drives everything except ready; rx is its mirror.
interface t_DATA_STREAM #(
    parameter int DATA_WIDTH = 256
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            addr;
    logic                  sop;
    logic                  eop;

    modport tx (output valid, output data, output addr, output sop, output eop, input ready);
    modport rx (input valid, input data, input addr, input sop, input eop, output ready);
endinterface

// File: rtl/ds_payload_gen.sv
// ds_payload_gen -- per-lane payload source, TGT_DATA_WIDTH/32 lanes.
//   i_clk, i_reset : clock, synchronous active-high reset (re-seeds lanes)
//   i_load         : re-seed every lane
//   i_advance      : step every lane to the next beat
//   o_data         : payload of the current beat
//   o_data_next    : payload of the following beat, so the caller can
//                    present a new beat in the same cycle it advances
// LINEAR_PKTS != 0: lane k of beat n = n*lanes + k.
// LINEAR_PKTS == 0: lane k is a Galois LFSR seeded with LFSR_SEED + k.
module ds_payload_gen
    import ds_pkt_pkg::*;
#(
    parameter int          TGT_DATA_WIDTH = 256,
    parameter int          LINEAR_PKTS    = 0,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2021
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_load,
    input  logic                      i_advance,
    output logic [TGT_DATA_WIDTH-1:0] o_data,
    output logic [TGT_DATA_WIDTH-1:0] o_data_next
);

    localparam int LANES = lane_count(TGT_DATA_WIDTH);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] lane_r;
        logic [31:0] seed_s;
        logic [31:0] step_s;

        // Seed and next value for this lane in the selected payload mode.
        always_comb begin
            seed_s = 32'h0000_0000;
            step_s = lane_r;
            if (LINEAR_PKTS != 0) begin
                seed_s = 32'(k);
                step_s = lane_r + 32'(LANES);
            end else begin
                seed_s = LFSR_SEED + 32'(k);
                step_s = lfsr_step(lane_r);
            end
        end

        // Lane state: re-seed on reset or load, step on each accepted beat.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                lane_r <= seed_s;
            end else if (i_load) begin
                lane_r <= seed_s;
            end else if (i_advance) begin
                lane_r <= step_s;
            end else begin
                lane_r <= lane_r;
            end
        end

        assign o_data[32*k +: 32]      = lane_r;
        assign o_data_next[32*k +: 32] = step_s;
    end

endmodule

// File: rtl/ds_multi_pkt_gen.sv
// ds_multi_pkt_gen -- multi-beat packet generator driving a NAP data-stream
// TX interface. Destinations rotate round-robin over i_dest_list.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : rising edge starts a run, low requests a graceful stop
//   i_enable       : pause between beats when low
//   i_pkt_len      : beats per packet (0 behaves as 1)
//   i_num_pkts     : packets per run (0 = continuous)
//   i_dest_list    : NUM_DEST 4-bit addresses, entry 0 in the LSBs
//   o_pkt_count    : packets completed since the last start (saturating)
//   o_busy         : high in LOAD and SEND
//   o_done         : sticky, set once i_num_pkts packets have completed
//   if_data_stream : valid/ready/data/addr/sop/eop beat stream
// Optional build macro DS_PKT_HDR_INSERT_EN: data[31:0] of each sop beat
// carries {seq[15:0], len[7:0], 4'h0, addr[3:0]} instead of payload.
module ds_multi_pkt_gen
    import ds_pkt_pkg::*;
#(
    parameter int          TGT_DATA_WIDTH = 256,
    parameter int          NUM_DEST       = 4,
    parameter int          LEN_WIDTH      = 8,
    parameter int          CNT_WIDTH      = 16,
    parameter int          LINEAR_PKTS    = 0,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2021
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_enable,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    input  logic [CNT_WIDTH-1:0]  i_num_pkts,
    input  logic [NUM_DEST*4-1:0] i_dest_list,
    output logic [CNT_WIDTH-1:0]  o_pkt_count,
    output logic                  o_busy,
    output logic                  o_done,
    t_DATA_STREAM.tx              if_data_stream
);

    localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    gen_state_t                state_r, state_next_s;
    logic                      valid_r, valid_next_s;
    logic                      sop_r, sop_next_s;
    logic                      eop_r, eop_next_s;
    logic [3:0]                addr_r, addr_next_s;
    logic [TGT_DATA_WIDTH-1:0] data_r, data_next_s;
    logic [LEN_WIDTH-1:0]      beat_idx_r, beat_idx_next_s, beat_idx_adv_s;
    logic [DEST_W-1:0]         dest_idx_r, dest_idx_next_s, dest_idx_adv_s;
    logic [CNT_WIDTH-1:0]      pkt_count_r, pkt_count_next_s, pkt_count_adv_s;
    logic [LEN_WIDTH-1:0]      len_r, len_next_s;
    logic [CNT_WIDTH-1:0]      num_r, num_next_s;
    logic                      done_r, done_next_s;
    logic                      busy_r, busy_next_s;
    logic                      start_q_r;

    logic                      accept_s;
    logic                      eop_acc_s;
    logic                      last_pkt_s;
    logic                      start_rise_s;
    logic                      gen_load_s;
    logic                      beat_sop_s;
    logic                      beat_eop_s;
    logic [3:0]                beat_addr_s;
    logic [TGT_DATA_WIDTH-1:0] payload_s;
    logic [TGT_DATA_WIDTH-1:0] beat_data_s;
    logic [TGT_DATA_WIDTH-1:0] gen_data_s;
    logic [TGT_DATA_WIDTH-1:0] gen_next_s;

    ds_payload_gen #(
        .TGT_DATA_WIDTH (TGT_DATA_WIDTH),
        .LINEAR_PKTS    (LINEAR_PKTS),
        .LFSR_SEED      (LFSR_SEED)
    ) u_payload (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (gen_load_s),
        .i_advance   (accept_s),
        .o_data      (gen_data_s),
        .o_data_next (gen_next_s)
    );

    // Handshake decode and the index/counter values after this cycle's acceptance.
    always_comb begin
        accept_s        = valid_r & if_data_stream.ready;
        eop_acc_s       = accept_s & eop_r;
        start_rise_s    = i_start & ~start_q_r;
        beat_idx_adv_s  = beat_idx_r;
        dest_idx_adv_s  = dest_idx_r;
        pkt_count_adv_s = pkt_count_r;
        last_pkt_s      = 1'b0;
        if (accept_s) begin
            if (eop_r) begin
                beat_idx_adv_s = {LEN_WIDTH{1'b0}};
            end else begin
                beat_idx_adv_s = beat_idx_r + LEN_WIDTH'(1);
            end
        end else begin
            beat_idx_adv_s = beat_idx_r;
        end
        if (eop_acc_s) begin
            if (dest_idx_r == DEST_W'(NUM_DEST - 1)) begin
                dest_idx_adv_s = {DEST_W{1'b0}};
            end else begin
                dest_idx_adv_s = dest_idx_r + DEST_W'(1);
            end
            if (&pkt_count_r) begin
                pkt_count_adv_s = pkt_count_r;
            end else begin
                pkt_count_adv_s = pkt_count_r + CNT_WIDTH'(1);
            end
            // Compared one bit wider so a count of all-ones cannot wrap.
            last_pkt_s = (num_r != {CNT_WIDTH{1'b0}}) &&
                         (({1'b0, pkt_count_r} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, num_r});
        end else begin
            dest_idx_adv_s  = dest_idx_r;
            pkt_count_adv_s = pkt_count_r;
            last_pkt_s      = 1'b0;
        end
    end

    // Content of the beat that would be presented next.
    always_comb begin
        beat_sop_s  = (beat_idx_adv_s == {LEN_WIDTH{1'b0}});
        beat_eop_s  = (beat_idx_adv_s == (len_r - LEN_WIDTH'(1)));
        beat_addr_s = i_dest_list[{dest_idx_adv_s, 2'b00} +: 4];
        // On acceptance the generator steps this same edge, so take its next value.
        if (accept_s) begin
            payload_s = gen_next_s;
        end else begin
            payload_s = gen_data_s;
        end
        beat_data_s = payload_s;
`ifdef DS_PKT_HDR_INSERT_EN
        if (beat_sop_s) begin
            beat_data_s[31:0] = build_hdr(16'(pkt_count_adv_s), 8'(len_r), beat_addr_s);
        end else begin
            beat_data_s[31:0] = payload_s[31:0];
        end
`endif
    end

    // Next-state and next-output logic of the generator state machine.
    always_comb begin
        state_next_s     = state_r;
        valid_next_s     = valid_r;
        sop_next_s       = sop_r;
        eop_next_s       = eop_r;
        addr_next_s      = addr_r;
        data_next_s      = data_r;
        beat_idx_next_s  = beat_idx_adv_s;
        dest_idx_next_s  = dest_idx_adv_s;
        pkt_count_next_s = pkt_count_adv_s;
        len_next_s       = len_r;
        num_next_s       = num_r;
        done_next_s      = done_r;
        gen_load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (i_pkt_len == {LEN_WIDTH{1'b0}}) begin
                    len_next_s = LEN_WIDTH'(1);
                end else begin
                    len_next_s = i_pkt_len;
                end
                num_next_s       = i_num_pkts;
                beat_idx_next_s  = {LEN_WIDTH{1'b0}};
                dest_idx_next_s  = {DEST_W{1'b0}};
                pkt_count_next_s = {CNT_WIDTH{1'b0}};
                done_next_s      = 1'b0;
                gen_load_s       = 1'b1;
                state_next_s     = SEND;
            end
            SEND: begin
                if (valid_r && !if_data_stream.ready) begin
                    // Stalled beat: everything holds.
                    state_next_s = SEND;
                end else if (last_pkt_s) begin
                    valid_next_s = 1'b0;
                    done_next_s  = 1'b1;
                    state_next_s = DONE;
                end else if (eop_acc_s && !i_start) begin
                    valid_next_s = 1'b0;
                    state_next_s = IDLE;
                end else if (!valid_r && (beat_idx_r == {LEN_WIDTH{1'b0}}) && !i_start) begin
                    // Stop requested while paused on a packet boundary.
                    state_next_s = IDLE;
                end else if (i_enable) begin
                    valid_next_s = 1'b1;
                    sop_next_s   = beat_sop_s;
                    eop_next_s   = beat_eop_s;
                    addr_next_s  = beat_addr_s;
                    data_next_s  = beat_data_s;
                    state_next_s = SEND;
                end else begin
                    valid_next_s = 1'b0;
                    state_next_s = SEND;
                end
            end
            DONE: begin
                if (!i_start) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = IDLE;
            end
        endcase
        busy_next_s = (state_next_s == LOAD) || (state_next_s == SEND);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= IDLE;
            valid_r     <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            addr_r      <= 4'h0;
            data_r      <= {TGT_DATA_WIDTH{1'b0}};
            beat_idx_r  <= {LEN_WIDTH{1'b0}};
            dest_idx_r  <= {DEST_W{1'b0}};
            pkt_count_r <= {CNT_WIDTH{1'b0}};
            len_r       <= LEN_WIDTH'(1);
            num_r       <= {CNT_WIDTH{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            start_q_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            valid_r     <= valid_next_s;
            sop_r       <= sop_next_s;
            eop_r       <= eop_next_s;
            addr_r      <= addr_next_s;
            data_r      <= data_next_s;
            beat_idx_r  <= beat_idx_next_s;
            dest_idx_r  <= dest_idx_next_s;
            pkt_count_r <= pkt_count_next_s;
            len_r       <= len_next_s;
            num_r       <= num_next_s;
            done_r      <= done_next_s;
            busy_r      <= busy_next_s;
            start_q_r   <= i_start;
        end
    end

    assign if_data_stream.valid = valid_r;
    assign if_data_stream.sop   = sop_r;
    assign if_data_stream.eop   = eop_r;
    assign if_data_stream.addr  = addr_r;
    assign if_data_stream.data  = data_r;
    assign o_pkt_count          = pkt_count_r;
    assign o_busy               = busy_r;
    assign o_done               = done_r;

endmodule

// File: doc/ds_multi_pkt_gen.md
Name: ds_multi_pkt_gen

Overview:
Parametrised data-streaming packet generator, successor to the single-flit generator.
- Emits multi-beat packets with real sop/eop framing, programmable length and packet count.
- Destinations rotate round-robin over a configurable list.
- Drives a NAP data-stream TX interface so a peer NAP can check traffic across the NoC.
- Fully AXI-style: valid is never withdrawn and data never changes until accepted.

Parameters:
- TGT_DATA_WIDTH, 256: beat width in bits; must be a multiple of 32.
- NUM_DEST, 4: number of entries in the destination list, 1..16.
- LEN_WIDTH, 8: width of the packet-length field.
- CNT_WIDTH, 16: width of the packet-count and status counters.
- LINEAR_PKTS, 0: 1 selects linear payload; 0 selects LFSR payload.
- LFSR_SEED, 32'hACE1_2021: base seed for the LFSR lanes.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  level; rising edge restarts the sequence; low requests a graceful stop.
- i_enable  in  1  pause when low; takes effect between beats.
- i_pkt_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- i_num_pkts  in  CNT_WIDTH  packets per run; 0 means continuous.
- i_dest_list  in  NUM_DEST*4  4-bit NAP addresses, entry 0 in the LSBs.
- o_pkt_count  out  CNT_WIDTH  packets completed (eop accepted) since the last start.
- o_busy  out  1  high while a run is active.
- o_done  out  1  sticky; set when i_num_pkts packets have completed.
- if_data_stream  t_DATA_STREAM.tx  -  carries valid, ready, data, addr, sop, eop.

Behaviour:
- Reset: valid, sop, eop, o_busy, o_done = 0; o_pkt_count = 0; addr = 0; data = 0; state = IDLE.
- Beat accepted = valid & ready.
- State machine:
  - IDLE -> LOAD on a registered rising edge of i_start.
  - LOAD, one cycle: capture i_pkt_len and i_num_pkts; reset beat index, destination index and o_pkt_count; clear o_done; re-seed the payload generator. Then -> SEND.
  - SEND presents beats.
  - SEND -> DONE when the final eop is accepted and the packet count has been reached.
  - SEND -> IDLE when an eop is accepted while i_start is low.
  - DONE holds until i_start falls, then -> IDLE.
- Beat presentation:
  - In SEND, if valid = 0 and i_enable = 1, assert valid on the next cycle.
  - After acceptance, the next beat is presented in the following cycle with no bubble, provided i_enable = 1 and the packet or run is not finished.
  - Sustained throughput is one beat per clock while ready = 1.
- Hold rule: while valid & !ready, data, addr, sop and eop are held, independent of i_enable and i_start.
- Framing:
  - sop = 1 on beat 0; eop = 1 on beat len-1.
  - For len = 1, sop = eop = 1 on the same beat.
- Addressing: addr = i_dest_list[dest_idx]. dest_idx increments modulo NUM_DEST on eop acceptance and is constant within a packet.
- o_pkt_count increments on eop acceptance and saturates at all-ones.
- o_busy = 1 in LOAD and SEND.
- Stopping and restart:
  - If i_start falls mid-packet, the packet completes through eop; no truncation.
  - A new rising edge of i_start during SEND is ignored until IDLE is reached.
- Payload generator:
  - Advances only on acceptance.
  - LINEAR mode: 32-bit lane k of global beat n = n*(TGT_DATA_WIDTH/32)+k, mod 2^32.
  - LFSR mode: lane k is a 32-bit Galois LFSR, polynomial 0x80200003, seeded with LFSR_SEED + k.
- Mid-run i_pkt_len / i_num_pkts changes are ignored until the next LOAD.
- Reset mid-packet: outputs return to reset values in the next cycle; no eop is emitted.

Optional Feature:
- Macro: DS_PKT_HDR_INSERT_EN.
- Defined: data[31:0] of every sop beat is replaced by a header, {seq[15:0], len[7:0], 4'h0, addr[3:0]}. seq = o_pkt_count at sop. The LFSR still advances for that beat.
- Undefined: all beats carry pure payload; no header logic is synthesised.

Decomposition:
- Package ds_pkt_pkg holds:
  - gen_state_t enum (IDLE, LOAD, SEND, DONE);
  - LFSR_POLY constant;
  - header field offsets;
  - a function computing lane count from TGT_DATA_WIDTH.
- Sub-module ds_payload_gen: per-lane LFSR/linear generator with i_load, i_advance and o_data, replicated over TGT_DATA_WIDTH/32 lanes.

Test Plan:
- len=4, num=3, dest={1,2,3,4}, ready=1 -> 12 back-to-back beats. sop on beats 0/4/8, eop on beats 3/7/11, addr 1,1,1,1,2,2,2,2,3,3,3,3. o_done=1, o_pkt_count=3.
- len=0, num=2 -> two single-beat packets, each with sop=eop=1; o_pkt_count=2.
- Ready toggling 1010… with len=8 -> data/addr/sop/eop stable during every stall. Linear lane 0 sequence 0,8,16,…,56 with no gaps or duplicates.
- i_start dropped at beat 2 of len=6, num=0 -> beats 3..5 still sent, eop on beat 5, then IDLE and valid=0.
- i_enable low for 5 cycles mid-packet with valid pending and ready=0 -> valid held until accepted; no new beat while disabled.
- i_reset=1 mid-packet -> next cycle valid=0, o_pkt_count=0. A new start replays the identical LFSR sequence from LFSR_SEED.
